// File: rtl/rgb565_gen_binarize.sv
`timescale 1ns/1ps
// Gray-ramp RGB565 raster source feeding a luma threshold pipeline (0x00/0xFF out).
// Latency: gen_* lag counters by 1 clk, post_* lag gen_* by 3 clk; free-running, no backpressure.
module rgb565_gen_binarize #(
  parameter int ACTIVE_IW  = 640,
  parameter int ACTIVE_IH  = 480,
  parameter int TOTAL_IW   = 800,
  parameter int TOTAL_IH   = 525,
  parameter int H_START    = 143,
  parameter int V_START    = 34,
  parameter int H_SYNC     = 96,
  parameter int BIN_THRESH = 150
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        gen_vs,
  output logic        gen_hs,
  output logic        gen_de,
  output logic [15:0] gen_data,
  output logic        post_frame_vsync,
  output logic        post_frame_hsync,
  output logic        post_frame_de,
  output logic [7:0]  post_rgb
);

  localparam int HW = $clog2(TOTAL_IW);
  localparam int VW = $clog2(TOTAL_IH);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          v_act;
  logic          h_act;
  logic [7:0]    x;
  logic [4:0]    x5;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HW'(TOTAL_IW - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VW'(TOTAL_IH - 1)) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign v_act = (v_cnt >= VW'(V_START)) && (v_cnt < VW'(V_START + ACTIVE_IH));
  assign h_act = (h_cnt >= HW'(H_START)) && (h_cnt < HW'(H_START + ACTIVE_IW));
  // Only x[7:3] shapes the ramp, so the 256-pixel period falls out of the truncation.
  assign x     = 8'(h_cnt - HW'(H_START));
  assign x5    = x[7:3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_vs   <= 1'b0;
      gen_hs   <= 1'b1;
      gen_de   <= 1'b0;
      gen_data <= '0;
    end else begin
      gen_vs   <= v_act;
      gen_hs   <= (h_cnt >= HW'(H_SYNC));
      gen_de   <= v_act && h_act;
      gen_data <= (v_act && h_act) ? {x5, x5, x[7], x5} : 16'h0000;
    end
  end

  logic [4:0]  r5;
  logic [5:0]  g6;
  logic [4:0]  b5;
  logic [7:0]  r8;
  logic [7:0]  g8;
  logic [7:0]  b8;
  logic [15:0] p_r;
  logic [15:0] p_g;
  logic [15:0] p_b;
  logic [16:0] sum;
  logic [1:0]  vs_p;
  logic [1:0]  hs_p;
  logic [1:0]  de_p;

  assign r5 = gen_data[15:11];
  assign g6 = gen_data[10:5];
  assign b5 = gen_data[4:0];
  assign r8 = {r5, r5[4:2]};
  assign g8 = {g6, g6[5:4]};
  assign b8 = {b5, b5[4:2]};

  // Green product reaches 150*255 = 38250, so products are carried at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r              <= '0;
      p_g              <= '0;
      p_b              <= '0;
      sum              <= '0;
      vs_p             <= '0;
      hs_p             <= '1;
      de_p             <= '0;
      post_frame_vsync <= 1'b0;
      post_frame_hsync <= 1'b1;
      post_frame_de    <= 1'b0;
      post_rgb         <= 8'h00;
    end else begin
      p_r              <= {8'd0, r8} * 16'd77;
      p_g              <= {8'd0, g8} * 16'd150;
      p_b              <= {8'd0, b8} * 16'd29;
      sum              <= {1'b0, p_r} + {1'b0, p_g} + {1'b0, p_b};
      vs_p             <= {vs_p[0], gen_vs};
      hs_p             <= {hs_p[0], gen_hs};
      de_p             <= {de_p[0], gen_de};
      post_frame_vsync <= vs_p[1];
      post_frame_hsync <= hs_p[1];
      post_frame_de    <= de_p[1];
      post_rgb         <= (de_p[1] && (sum[16:8] > 9'(BIN_THRESH))) ? 8'hFF : 8'h00;
    end
  end

endmodule

// File: tb/tb_rgb565_gen_binarize.sv
`timescale 1ns/1ps
// Bench for rgb565_gen_binarize with a shortened vertical raster so whole frames fit the run.
module tb_rgb565_gen_binarize;

  localparam int AW    = 640;
  localparam int AH    = 3;
  localparam int TW    = 800;
  localparam int TH    = 6;
  localparam int HS    = 143;
  localparam int VS    = 2;
  localparam int HSY   = 96;
  localparam int BT    = 150;
  localparam int FRAME = TW * TH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gen_vs, gen_hs, gen_de;
  logic [15:0] gen_data;
  logic        post_frame_vsync, post_frame_hsync, post_frame_de;
  logic [7:0]  post_rgb;

  rgb565_gen_binarize #(
    .ACTIVE_IW(AW), .ACTIVE_IH(AH), .TOTAL_IW(TW), .TOTAL_IH(TH),
    .H_START(HS), .V_START(VS), .H_SYNC(HSY), .BIN_THRESH(BT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .gen_vs(gen_vs), .gen_hs(gen_hs), .gen_de(gen_de), .gen_data(gen_data),
    .post_frame_vsync(post_frame_vsync), .post_frame_hsync(post_frame_hsync),
    .post_frame_de(post_frame_de), .post_rgb(post_rgb)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int n = 0;
  int gx, px;
  logic ev, eh, ed, pv, ph, pd;
  logic [15:0] edat, pdat;
  logic [7:0]  prgb;

  // Raster outputs seen at edge k: position k-1 of the frame, reset values before edge 1.
  function automatic void gen_model(input int k, output logic vs, output logic hs,
                                    output logic de, output logic [15:0] d);
    int p, h, v, xx, r5, g6;
    if (k < 1) begin
      vs = 1'b0; hs = 1'b1; de = 1'b0; d = 16'h0;
    end else begin
      p  = (k - 1) % FRAME;
      h  = p % TW;
      v  = p / TW;
      vs = (v >= VS) && (v < VS + AH);
      hs = (h >= HSY);
      de = vs && (h >= HS) && (h < HS + AW);
      xx = (h - HS + 1024) % 256;
      r5 = xx / 8;
      g6 = r5 * 2 + xx / 128;
      d  = de ? 16'(r5 * 2048 + g6 * 32 + r5) : 16'h0;
    end
  endfunction

  function automatic int luma(input logic [15:0] d);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(d[15:11]);
    g6 = int'(d[10:5]);
    b5 = int'(d[4:0]);
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return (77 * r8 + 150 * g8 + 29 * b8) / 256;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
    gen_model(n, ev, eh, ed, edat);
    gen_model(n - 3, pv, ph, pd, pdat);
    prgb = (pd && luma(pdat) > BT) ? 8'hFF : 8'h00;
    gx = ((n - 1) % FRAME) % TW - HS;
    px = (n >= 4) ? ((n - 4) % FRAME) % TW - HS : -1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (gen_vs !== 1'b0) $display("FAIL rst_gen_vs: got %b want 0", gen_vs); else passed++;
    total++; if (gen_hs !== 1'b1) $display("FAIL rst_gen_hs: got %b want 1", gen_hs); else passed++;
    total++; if (gen_de !== 1'b0) $display("FAIL rst_gen_de: got %b want 0", gen_de); else passed++;
    total++; if (gen_data !== 16'h0) $display("FAIL rst_gen_data: got %h want 0000", gen_data); else passed++;
    total++; if (post_frame_vsync !== 1'b0) $display("FAIL rst_post_vs: got %b want 0", post_frame_vsync); else passed++;
    total++; if (post_frame_hsync !== 1'b1) $display("FAIL rst_post_hs: got %b want 1", post_frame_hsync); else passed++;
    total++; if (post_frame_de !== 1'b0) $display("FAIL rst_post_de: got %b want 0", post_frame_de); else passed++;
    total++; if (post_rgb !== 8'h00) $display("FAIL rst_post_rgb: got %h want 00", post_rgb); else passed++;
    release_reset();
  endtask

  task automatic test_frame();
    int errs = 0, err_n = -1, de_cnt = 0, vs_cnt = 0, hs_low = 0, white = 0;
    int first_de = -1, first_pde = -1, vs_fall = -1, pvs_fall = -1, vs_r1 = -1, vs_r2 = -1;
    logic [15:0] first_data = 16'hDEAD;
    logic [7:0]  first_prgb = 8'hAA;
    logic [29:0] err_got = '0, err_exp = '0;
    logic p_vs = 1'b0, p_pvs = 1'b0, p_de = 1'b0, p_pde = 1'b0;
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      tick();
      if ({gen_vs, gen_hs, gen_de, gen_data, post_frame_vsync, post_frame_hsync, post_frame_de, post_rgb}
          !== {ev, eh, ed, edat, pv, ph, pd, prgb}) begin
        errs++;
        if (err_n < 0) begin
          err_n   = n;
          err_got = {gen_vs, gen_hs, gen_de, gen_data, post_frame_vsync, post_frame_hsync, post_frame_de, post_rgb};
          err_exp = {ev, eh, ed, edat, pv, ph, pd, prgb};
        end
      end
      if (n <= FRAME) begin
        de_cnt += int'(gen_de);
        vs_cnt += int'(gen_vs);
        hs_low += int'(!gen_hs);
      end
      if (n >= 4 && n <= FRAME + 3 && post_rgb === 8'hFF) white++;
      if (gen_de && !p_de && first_de < 0) begin first_de = n; first_data = gen_data; end
      if (post_frame_de && !p_pde && first_pde < 0) begin first_pde = n; first_prgb = post_rgb; end
      if (!gen_vs && p_vs && vs_fall < 0) vs_fall = n;
      if (!post_frame_vsync && p_pvs && pvs_fall < 0) pvs_fall = n;
      if (gen_vs && !p_vs) begin
        if (vs_r1 < 0) vs_r1 = n; else if (vs_r2 < 0) vs_r2 = n;
      end
      p_vs = gen_vs; p_pvs = post_frame_vsync; p_de = gen_de; p_pde = post_frame_de;
      if (ed && gx == 151) begin
        total++; if (gen_data !== 16'h94B2) $display("FAIL x151_data: got %h want 94B2 at edge %0d", gen_data, n); else passed++;
      end
      if (ed && gx == 152) begin
        total++; if (gen_data !== 16'h9CF3) $display("FAIL x152_data: got %h want 9CF3 at edge %0d", gen_data, n); else passed++;
      end
      if (ed && gx == 255) begin
        total++; if (gen_data !== 16'hFFFF) $display("FAIL x255_data: got %h want FFFF at edge %0d", gen_data, n); else passed++;
      end
      if (pd && px == 151) begin
        total++; if (post_rgb !== 8'h00) $display("FAIL x151_bin: got %h want 00 at edge %0d", post_rgb, n); else passed++;
      end
      if (pd && px == 152) begin
        total++; if (post_rgb !== 8'hFF) $display("FAIL x152_bin: got %h want FF at edge %0d", post_rgb, n); else passed++;
      end
      if (pd && px == 255) begin
        total++; if (post_rgb !== 8'hFF) $display("FAIL x255_bin: got %h want FF at edge %0d", post_rgb, n); else passed++;
      end
    end
    total++; if (errs !== 0) $display("FAIL stream: %0d bad cycles, first at edge %0d got %h want %h", errs, err_n, err_got, err_exp); else passed++;
    total++; if (de_cnt !== AW * AH) $display("FAIL de_count: got %0d want %0d", de_cnt, AW * AH); else passed++;
    total++; if (vs_cnt !== AH * TW) $display("FAIL vs_count: got %0d want %0d", vs_cnt, AH * TW); else passed++;
    total++; if (hs_low !== HSY * TH) $display("FAIL hs_low_count: got %0d want %0d", hs_low, HSY * TH); else passed++;
    total++; if (white !== 208 * AH) $display("FAIL white_count: got %0d want %0d", white, 208 * AH); else passed++;
    total++; if (first_de !== VS * TW + HS + 1) $display("FAIL first_de_edge: got %0d want %0d", first_de, VS * TW + HS + 1); else passed++;
    total++; if (first_data !== 16'h0000) $display("FAIL first_data: got %h want 0000", first_data); else passed++;
    total++; if (first_pde !== VS * TW + HS + 4) $display("FAIL first_post_de_edge: got %0d want %0d", first_pde, VS * TW + HS + 4); else passed++;
    total++; if (first_prgb !== 8'h00) $display("FAIL first_post_rgb: got %h want 00", first_prgb); else passed++;
    total++; if (vs_fall !== (VS + AH) * TW + 1) $display("FAIL vs_fall_edge: got %0d want %0d", vs_fall, (VS + AH) * TW + 1); else passed++;
    total++; if (pvs_fall - vs_fall !== 3) $display("FAIL post_vs_fall_delay: got %0d want 3", pvs_fall - vs_fall); else passed++;
    total++; if (vs_r2 - vs_r1 !== FRAME) $display("FAIL frame_period: got %0d want %0d", vs_r2 - vs_r1, FRAME); else passed++;
  endtask

  task automatic test_async_reset();
    int tp;
    tp = VS * TW + HS + int'($urandom_range(AW - 1)) + TW * int'($urandom_range(AH - 1));
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (((n - 1) % FRAME) == tp) break;
    end
    total++; if (gen_de !== 1'b1) $display("FAIL pre_reset_de: got %b want 1 at edge %0d", gen_de, n); else passed++;
    #($urandom_range(1, 5));
    rst_n = 1'b0;
    #1;
    total++; if ({gen_vs, gen_hs, gen_de, gen_data} !== {1'b0, 1'b1, 1'b0, 16'h0})
      $display("FAIL async_gen: got %h want %h", {gen_vs, gen_hs, gen_de, gen_data}, {1'b0, 1'b1, 1'b0, 16'h0}); else passed++;
    total++; if ({post_frame_vsync, post_frame_hsync, post_frame_de, post_rgb} !== {1'b0, 1'b1, 1'b0, 8'h00})
      $display("FAIL async_post: got %h want %h", {post_frame_vsync, post_frame_hsync, post_frame_de, post_rgb}, {1'b0, 1'b1, 1'b0, 8'h00}); else passed++;
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  task automatic test_restart();
    int errs = 0, err_n = -1, first_de = -1;
    logic p_de = 1'b0;
    for (int i = 0; i < VS * TW + HS + 20; i++) begin
      tick();
      if ({gen_vs, gen_hs, gen_de, gen_data, post_frame_vsync, post_frame_hsync, post_frame_de, post_rgb}
          !== {ev, eh, ed, edat, pv, ph, pd, prgb}) begin
        errs++;
        if (err_n < 0) err_n = n;
      end
      if (gen_de && !p_de && first_de < 0) first_de = n;
      p_de = gen_de;
    end
    total++; if (errs !== 0) $display("FAIL restart_stream: %0d bad cycles, first at edge %0d want 0 bad", errs, err_n); else passed++;
    total++; if (first_de !== VS * TW + HS + 1) $display("FAIL restart_first_de: got %0d want %0d", first_de, VS * TW + HS + 1); else passed++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_async_reset();
    test_restart();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
